// File: rtl/neuron_mac_pkg.sv
// Shared constants and FSM state type for the NAR-Net hidden-layer neuron.
package narnet_pkg;

    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 5;
    localparam int PROD_W    = 16;
    localparam int SAT_MAX   = 127;
    localparam int SAT_MIN   = -128;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        ADDR,
        LOOKUP,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_mac_if.sv
// Handshake and data bundle between the neuron MAC, its feeder and the tanh LUT.
interface neuron_mac_if;
    import narnet_pkg::*;

    logic              start;
    logic [DATA_W-1:0] bias;
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] w_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tanh_addr;
    logic [DATA_W-1:0] tanh_data;
    logic [DATA_W-1:0] y_out;
    logic              y_valid;
    logic              busy;

    modport master (
        output start, bias, x_in, w_in, in_valid, tanh_data,
        input  in_ready, tanh_addr, y_out, y_valid, busy
    );

    modport slave (
        input  start, bias, x_in, w_in, in_valid, tanh_data,
        output in_ready, tanh_addr, y_out, y_valid, busy
    );

endinterface

// File: rtl/neuron_mac_sat.sv
// Rescale the Q-format accumulator back to Q3.5 and clamp it into a signed 8-bit LUT address.
module neuron_sat
    import narnet_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] addr,
    output logic                     clamp
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        clamp   = 1'b0;
        addr    = shifted[DATA_W-1:0];
        if (shifted > ACC_W'(SAT_MAX)) begin
            addr  = DATA_W'(SAT_MAX);
            clamp = 1'b1;
        end else if (shifted < ACC_W'(SAT_MIN)) begin
            addr  = DATA_W'(SAT_MIN);
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: bias + sum(x*w), rescale/saturate to a tanh LUT address, capture the LUT result.
// Optional NEURON_MAC_SAT_FLAG_EN adds a registered sat_flag output reporting clamping.
module neuron_mac
    import narnet_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  nif
`ifdef NEURON_MAC_SAT_FLAG_EN
    ,
    output logic         sat_flag
`endif
);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic        [7:0]       cnt;
    logic signed [PROD_W-1:0] prod;
    logic        [DATA_W-1:0] sat_addr;
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic                    clamp;
`else
    logic                    clamp_unused;
`endif

    assign prod = $signed(nif.x_in) * $signed(nif.w_in);

    neuron_sat #(.ACC_W(ACC_W)) u_sat (
        .acc   (acc),
        .addr  (sat_addr),
`ifdef NEURON_MAC_SAT_FLAG_EN
        .clamp (clamp)
`else
        .clamp (clamp_unused)
`endif
    );

    // Bias is Q3.5; shifting left by FRAC_BITS aligns it with the Q6.10 products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            nif.in_ready  <= 1'b0;
            nif.tanh_addr <= '0;
            nif.y_out     <= '0;
            nif.y_valid   <= 1'b0;
            nif.busy      <= 1'b0;
`ifdef NEURON_MAC_SAT_FLAG_EN
            sat_flag      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (nif.start) begin
                        acc          <= ACC_W'($signed(nif.bias)) <<< FRAC_BITS;
                        cnt          <= '0;
                        nif.in_ready <= 1'b1;
                        nif.busy     <= 1'b1;
                        state        <= ACC;
                    end
                end
                ACC: begin
                    if (nif.in_valid && nif.in_ready) begin
                        acc <= acc + ACC_W'(prod);
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(N_INPUTS - 1)) begin
                            nif.in_ready <= 1'b0;
                            state        <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    nif.tanh_addr <= sat_addr;
`ifdef NEURON_MAC_SAT_FLAG_EN
                    sat_flag      <= clamp;
`endif
                    state         <= LOOKUP;
                end
                LOOKUP: begin
                    nif.y_out   <= nif.tanh_data;
                    nif.y_valid <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    nif.y_valid <= 1'b0;
                    nif.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac with a negedge tanh LUT model; honours NEURON_MAC_SAT_FLAG_EN.
module tb_neuron_mac;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] y;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   expected_pulses = 0;
    exp_t expq[$];
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic sat_flag;
`endif

    neuron_mac_if nif ();

    neuron_mac #(.N_INPUTS(4), .ACC_W(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .nif      (nif)
`ifdef NEURON_MAC_SAT_FLAG_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    // Bench-side tanh LUT contents, opaque to the block.
    function automatic logic [7:0] lut(input logic [7:0] a);
        case (a)
            8'h7F:   lut = 8'h30;
            8'h10:   lut = 8'h07;
            8'hF0:   lut = 8'hF9;
            8'h03:   lut = 8'h01;
            default: lut = a ^ 8'hA5;
        endcase
    endfunction

    initial nif.tanh_data = 8'h00;
    always @(negedge clk) nif.tanh_data <= lut(nif.tanh_addr);

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && nif.y_valid) begin
            exp_t e;
            pulses++;
            if (expq.size() == 0) begin
                check_output("spurious_y_valid", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check_output("y_out", {24'd0, nif.y_out}, {24'd0, e.y});
                check_output("tanh_addr_at_valid", {24'd0, nif.tanh_addr}, {24'd0, e.addr});
`ifdef NEURON_MAC_SAT_FLAG_EN
                check_output("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
`endif
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, "_in_ready"}, {31'd0, nif.in_ready}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, nif.busy}, 32'd0);
        check_output({tag, "_y_valid"}, {31'd0, nif.y_valid}, 32'd0);
        check_output({tag, "_tanh_addr"}, {24'd0, nif.tanh_addr}, 32'd0);
        check_output({tag, "_y_out"}, {24'd0, nif.y_out}, 32'd0);
`ifdef NEURON_MAC_SAT_FLAG_EN
        check_output({tag, "_sat_flag"}, {31'd0, sat_flag}, 32'd0);
`endif
    endtask

    // Caller must be just after a clock edge; start is sampled on the next posedge.
    task automatic apply_stimulus(input logic [7:0] b, input logic [3:0][7:0] xs,
                                  input logic [3:0][7:0] ws, input bit stall,
                                  input bit start_busy, input bit abort);
        int   a;
        int   sh;
        int   n;
        int   cyc;
        bit   v;
        exp_t e;
        a = int'($signed(b)) * 32;
        for (int i = 0; i < 4; i++) a += int'($signed(xs[i])) * int'($signed(ws[i]));
        sh = a >>> 5;
        e.sat = 1'b1;
        if (sh > 127)       e.addr = 8'h7F;
        else if (sh < -128) e.addr = 8'h80;
        else begin
            e.addr = sh[7:0];
            e.sat  = 1'b0;
        end
        e.y = lut(e.addr);

        nif.start = 1'b1;
        nif.bias  = b;
        @(posedge clk);
        #1;
        nif.start = 1'b0;
        nif.bias  = 8'($urandom);
        if (!abort) begin
            expq.push_back(e);
            expected_pulses++;
        end
        check_output("acc_in_ready", {31'd0, nif.in_ready}, 32'd1);
        check_output("acc_busy", {31'd0, nif.busy}, 32'd1);

        n = 0;
        cyc = 0;
        v = 1'b1;
        while (n < 4 && cyc < 64) begin
            nif.in_valid = v;
            if (v) begin
                nif.x_in = xs[n];
                nif.w_in = ws[n];
            end else begin
                nif.x_in = 8'($urandom);
                nif.w_in = 8'($urandom | 1);
            end
            @(posedge clk);
            if (v) n++;
            cyc++;
            #1;
            if (stall) v = ~v;
            if (abort && n == 2) begin
                nif.in_valid = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_state("abort");
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
        if (cyc >= 64) check_output("accept_timeout", 32'd1, 32'd0);
        nif.in_valid = 1'b0;
        nif.x_in = 8'($urandom);
        nif.w_in = 8'($urandom);
        if (start_busy) nif.start = 1'b1;
        check_output("in_ready_after_last", {31'd0, nif.in_ready}, 32'd0);

        @(posedge clk);
        @(negedge clk);
        check_output("tanh_addr_k1", {24'd0, nif.tanh_addr}, {24'd0, e.addr});
        check_output("y_valid_k1", {31'd0, nif.y_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("y_valid_k2", {31'd0, nif.y_valid}, 32'd1);
        check_output("busy_done", {31'd0, nif.busy}, 32'd1);
        @(posedge clk);
        #1;
        nif.start = 1'b0;
        @(negedge clk);
        check_output("y_valid_k3", {31'd0, nif.y_valid}, 32'd0);
        check_output("busy_k3", {31'd0, nif.busy}, 32'd0);
        check_output("in_ready_k3", {31'd0, nif.in_ready}, 32'd0);
    endtask

    initial begin
        logic [3:0][7:0] xs;
        logic [3:0][7:0] ws;
        rst = 1'b1;
        nif.start = 1'b0;
        nif.bias = 8'h00;
        nif.x_in = 8'h00;
        nif.w_in = 8'h00;
        nif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        $display("[TB] full-scale saturation");
        apply_stimulus(8'd0, {4{8'd32}}, {4{8'd32}}, 1'b0, 1'b0, 1'b0);
        $display("[TB] small positive sum");
        apply_stimulus(8'd0, {8'd0, 8'd0, 8'd0, 8'd32}, {8'd0, 8'd0, 8'd0, 8'd16}, 1'b0, 1'b0, 1'b0);
        $display("[TB] negative sum");
        apply_stimulus(8'd0, {8'd0, 8'd0, 8'd0, 8'd32}, {8'd0, 8'd0, 8'd0, 8'hF0}, 1'b0, 1'b0, 1'b0);
        $display("[TB] bias only with stalls");
        apply_stimulus(8'd3, 32'($urandom), 32'd0, 1'b1, 1'b0, 1'b0);
        $display("[TB] reset mid-operation");
        apply_stimulus(8'd5, {4{8'd40}}, {4{8'd7}}, 1'b0, 1'b0, 1'b1);
        apply_stimulus(8'd0, {8'd0, 8'd0, 8'd0, 8'd32}, {8'd0, 8'd0, 8'd0, 8'd16}, 1'b0, 1'b0, 1'b0);
        $display("[TB] start ignored while busy");
        apply_stimulus(8'hF0, {8'd0, 8'd0, 8'd0, 8'd32}, {8'd0, 8'd0, 8'd0, 8'hF0}, 1'b0, 1'b1, 1'b0);
        apply_stimulus(8'd0, {4{8'd32}}, {4{8'd32}}, 1'b0, 1'b0, 1'b0);
        $display("[TB] random activations");
        for (int r = 0; r < 6; r++) begin
            xs = 32'($urandom);
            ws = 32'($urandom);
            apply_stimulus(8'($urandom), xs, ws, 1'($urandom), 1'b0, 1'b0);
        end
        apply_stimulus(8'h80, {4{8'h80}}, {4{8'h7F}}, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("y_valid_pulse_count", 32'(pulses), 32'(expected_pulses));
        check_output("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate stage for the NAR-Net hidden layer. It sits directly upstream of the tanh lookup table. It takes a bias and a streamed sequence of signed 8-bit input/weight pairs, accumulates their products at full precision, rescales and saturates the sum to an 8-bit signed LUT address, and drives that address into the tanh LUT. It then captures the LUT output and presents it as the neuron activation with a one-cycle valid pulse.

## Interface
- N_INPUTS, 4, number of input/weight pairs per activation (1..255)
- ACC_W, 20, accumulator width in bits (≥ 16 + clog2(N_INPUTS) + 1)
- clk  in  1  single clock; the design uses posedge only (the LUT it drives updates on negedge)
- rst  in  1  reset, asynchronous and active-high
- start  in  1  begin a new activation; sampled only in IDLE
- bias  in  8  signed Q3.5 bias; sampled together with start
- x_in  in  8  signed Q3.5 input sample
- w_in  in  8  signed Q3.5 weight
- in_valid  in  1  x_in/w_in pair present
- in_ready  out  1  block accepts a pair this cycle
- tanh_addr  out  8  registered LUT address, two's complement
- tanh_data  in  8  LUT output, treated as opaque data
- y_out  out  8  captured activation, held until the next capture
- y_valid  out  1  one-cycle pulse when y_out updates
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACC, ADDR, LOOKUP, DONE.
- IDLE: in_ready=0. When start=1, acc <= sign_ext(bias) <<< 5, cnt <= 0, and the FSM moves to ACC.
- ACC: in_ready=1. Each cycle with in_valid&in_ready, acc <= acc + sign_ext(x_in*w_in), where the product is 16-bit signed Q6.10, and cnt increments. On the beat where cnt==N_INPUTS-1 the FSM moves to ADDR. Cycles with in_valid=0 stall with no state change.
- ADDR: tanh_addr <= sat8(acc >>> 5), using an arithmetic shift and saturation to [-128, 127]. The FSM then moves to LOOKUP.
- LOOKUP: waits one cycle while the LUT resolves on the intervening negedge. y_out <= tanh_data, and the FSM moves to DONE.
- DONE: y_valid=1 for exactly this cycle, then the FSM returns to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACC.
- The accumulator never wraps, because ACC_W is sized for the worst-case sum.

## Timing
- Reset values: in_ready=0, tanh_addr=8'h00, y_out=8'h00, y_valid=0, busy=0, FSM=IDLE, acc=0, cnt=0.
- Last pair accepted at edge k gives the following sequence:
  - tanh_addr valid after edge k+1.
  - LUT output settles at the negedge between k+1 and k+2.
  - y_out updates at edge k+2.
  - y_valid is high from edge k+2 to edge k+3.
- Minimum activation period is N_INPUTS + 4 cycles: the start cycle, N accept cycles, ADDR, LOOKUP and DONE.
- Reset asserted mid-operation returns all state to reset values immediately. There is no partial output and no y_valid.
- start asserted in the same cycle as the DONE pulse is ignored. The next start is honoured from IDLE.

## Configuration
- NEURON_MAC_SAT_FLAG_EN
- Defined: adds output port sat_flag (1 bit, reset 0). It is registered in ADDR, set to 1 when clamping occurred, and held until the next ADDR.
- Undefined: the port is absent and the saturation logic is unchanged.

## Structure
- Package narnet_pkg:
  - DATA_W=8
  - FRAC_BITS=5
  - PROD_W=16
  - SAT_MAX=127, SAT_MIN=-128
  - the FSM state enum typedef
- Sub-module neuron_sat: combinational ACC_W-bit arithmetic shift by FRAC_BITS, saturation to 8 bits, and a clamp indicator.
- The tanh LUT is instantiated by the bench and the parent, not inside this block.

## Test plan
- **Full-scale saturation.** N=4, bias=0, x=32, w=32 for all four pairs. acc=4096, which saturates: tanh_addr=8'h7F, y_out=8'h30, y_valid at k+2, sat_flag=1.
- **Small positive sum.** bias=0; pairs (32,16),(0,0),(0,0),(0,0). tanh_addr=8'h10, y_out=8'h07, sat_flag=0.
- **Negative sum.** bias=0; pairs (32,-16),(0,0),(0,0),(0,0). tanh_addr=8'hF0, y_out=8'hF9.
- **Bias only, with stalls.** bias=3, all w=0, in_valid toggled 1-0-1-0… tanh_addr=8'h03, y_out=8'h01. Accept count is exactly 4, and stall cycles are not counted.
- **Reset mid-operation.** Assert rst after the 2nd accepted pair. All outputs are at reset values and no y_valid occurs. A following clean activation produces the correct result.
- **Start ignored while busy.** Pulse start in ADDR. Exactly one y_valid appears, busy falls after DONE, and a start in the next cycle begins a new activation.
